// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Widths, FSM state encoding and the ebreak opcode.
package fetch_pkg;

    localparam int ADDR_W = 64;
    localparam int INSN_W = 32;

    localparam logic [INSN_W-1:0] EBREAK_INSN = 32'h0010_0073;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection for the fetch sequencer: branch redirect,
// sequential step and wrap at the instruction memory size.
module fetch_pc_next
    import fetch_pkg::*;
#(
    parameter int MEM_BYTES = 64,
    parameter int PC_STEP   = 4
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              advance,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misaligned
);

    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(MEM_BYTES - 1);

    always_comb begin
        misaligned = branch_taken && (branch_target[1:0] != 2'b00);
        next_pc    = pc;
        if (branch_taken) begin
            if (!misaligned)
                next_pc = branch_target & MASK;
        end else if (advance) begin
            next_pc = (pc + ADDR_W'(PC_STEP)) & MASK;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, FSM and one-entry output stage.
// Define HALT_DETECT_EN to stop fetch on an ebreak instruction.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          MEM_BYTES = 64,
    parameter int          PC_STEP   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] Inst_Address,
    input  logic [INSN_W-1:0] instruction_in,
    output logic [INSN_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       fetch_count
);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic              misaligned;
    logic              advance;
    logic              capture;
    logic              go;
    logic              is_ebreak;

    fetch_pc_next #(
        .MEM_BYTES (MEM_BYTES),
        .PC_STEP   (PC_STEP)
    ) u_pc_next (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .advance       (advance),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
`ifdef HALT_DETECT_EN
        is_ebreak = (instruction_in == EBREAK_INSN);
`else
        is_ebreak = 1'b0;
`endif
        state_n = state;
        capture = 1'b0;
        advance = 1'b0;
        go      = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    if (misaligned)
                        state_n = FAULT;
                end else if (!inst_valid || inst_ready) begin
                    capture = 1'b1;
                    // ebreak is still delivered, but the PC parks on it
                    advance = !is_ebreak;
                    if (is_ebreak)
                        state_n = HALT;
                end
            end
            default: begin
                if (start) begin
                    state_n = RUN;
                    go      = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            inst_out    <= '0;
            inst_pc     <= '0;
            inst_valid  <= 1'b0;
            fetch_count <= '0;
        end else if (go) begin
            pc          <= RESET_PC;
            inst_valid  <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (inst_valid && inst_ready)
                fetch_count <= fetch_count + 32'd1;
            if (state == RUN) begin
                pc <= next_pc;
                if (branch_taken) begin
                    inst_valid <= 1'b0;
                end else if (capture) begin
                    inst_out   <= instruction_in;
                    inst_pc    <= pc;
                    inst_valid <= 1'b1;
                end
            end else if (inst_valid && inst_ready) begin
                inst_valid <= 1'b0;
            end
        end
    end

    assign Inst_Address = pc;
    assign fault        = (state == FAULT);
`ifdef HALT_DETECT_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
